// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with single-cycle logic/arithmetic ops and
// iterative (one bit per clock) multiply, unsigned divide and remainder.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset
//   start     in   1      operation request, sampled only while ready=1
//   A, B      in   WIDTH  operands
//   alusel    in   3      000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT,
//                         011 MUL, 100 DIVU, 101 REMU
//   ready     out  1      idle and able to accept start
//   done      out  1      one-cycle pulse: new result on aluout
//   aluout    out  WIDTH  registered result
//   zero      out  1      registered (aluout == 0)
//   overflow  out  1      registered signed overflow of ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       alusel,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] opa_reg;     // MUL: multiplicand (shifts left); DIV: dividend -> quotient
    logic [WIDTH-1:0] opb_reg;     // MUL: multiplier (shifts right);  DIV: divisor
    logic [WIDTH-1:0] acc_reg;     // MUL: partial product;             DIV: partial remainder
    logic [CW-1:0]    count_reg;
    logic             ready_reg;
    logic             done_reg;
    logic [WIDTH-1:0] aluout_reg;
    logic             zero_reg;
    logic             overflow_reg;

    assign ready    = ready_reg;
    assign done     = done_reg;
    assign aluout   = aluout_reg;
    assign zero     = zero_reg;
    assign overflow = overflow_reg;

    // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
    logic [WIDTH-1:0] sum, diff, fast_res;
    logic             fast_ovf, slt, is_multi;

    always_comb begin
        sum      = A + B;
        diff     = A - B;
        slt      = ($signed(A) < $signed(B));
        fast_res = '0;
        fast_ovf = 1'b0;
        is_multi = (alusel == OP_MUL) || (alusel == OP_DIVU) || (alusel == OP_REMU);
        case (alusel)
            OP_AND: fast_res = A & B;
            OP_OR:  fast_res = A | B;
            OP_ADD: begin
                fast_res = sum;
                fast_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res = diff;
                fast_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: fast_res = {{(WIDTH-1){1'b0}}, slt};
            default: begin
                fast_res = '0;
                fast_ovf = 1'b0;
            end
        endcase
    end

    // One iteration of shift-add multiply and of restoring division.
    // With divisor 0 the trial subtraction never borrows, so the quotient
    // fills with ones and the remainder ends up equal to the dividend.
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift, rem_trial;
    logic             div_ok;
    logic [WIDTH-1:0] rem_next, quo_next, step_res;

    always_comb begin
        mul_acc_next = acc_reg + (opb_reg[0] ? opa_reg : '0);
        rem_shift    = {acc_reg, opa_reg[WIDTH-1]};
        rem_trial    = rem_shift - {1'b0, opb_reg};
        div_ok       = ~rem_trial[WIDTH];
        rem_next     = div_ok ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next     = {opa_reg[WIDTH-2:0], div_ok};
        case (op_reg)
            OP_MUL:  step_res = mul_acc_next;
            OP_REMU: step_res = rem_next;
            default: step_res = quo_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= OP_AND;
            opa_reg      <= '0;
            opb_reg      <= '0;
            acc_reg      <= '0;
            count_reg    <= '0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            aluout_reg   <= '0;
            zero_reg     <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg  <= alusel;
                        opa_reg <= A;
                        opb_reg <= B;
                        acc_reg <= '0;
                        if (is_multi) begin
                            state_reg <= BUSY;
                            ready_reg <= 1'b0;
                            count_reg <= CW'(WIDTH);
                        end else begin
                            aluout_reg   <= fast_res;
                            zero_reg     <= (fast_res == '0);
                            overflow_reg <= fast_ovf;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // start is ignored here; only the iteration advances.
                    count_reg <= count_reg - CW'(1);
                    if (op_reg == OP_MUL) begin
                        acc_reg <= mul_acc_next;
                        opa_reg <= opa_reg << 1;
                        opb_reg <= opb_reg >> 1;
                    end else begin
                        acc_reg <= rem_next;
                        opa_reg <= quo_next;
                    end
                    if (count_reg == CW'(1)) begin
                        aluout_reg   <= step_res;
                        zero_reg     <= (step_res == '0);
                        overflow_reg <= 1'b0;
                        done_reg     <= 1'b1;
                        ready_reg    <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data path width in bits; legal values 8..64.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port start  input  1: operation request, sampled only when ready=1.
REQ-005 SHALL have port A  input  WIDTH: operand A.
REQ-006 SHALL have port B  input  WIDTH: operand B.
REQ-007 SHALL have port alusel  input  3: operation select.
REQ-008 SHALL have port ready  output  1: high when idle and able to accept start.
REQ-009 SHALL have port done  output  1: one-cycle pulse marking a new registered result.
REQ-010 SHALL have port aluout  output  WIDTH: registered result.
REQ-011 SHALL have port zero  output  1: registered, equals (aluout == 0).
REQ-012 SHALL have port overflow  output  1: registered signed overflow of ADD/SUB; 0 for all other ops.

Function
REQ-013 SHALL decode alusel: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 MUL (low WIDTH bits of unsigned product), 100 DIVU (quotient), 101 REMU (remainder).
REQ-014 SHALL implement a two-state FSM: IDLE (ready=1) and BUSY (ready=0).
REQ-015 SHALL, at an edge with state IDLE and start=1, latch A, B, alusel; inputs are don't-care at all other edges.
REQ-016 SHALL, for AND/OR/ADD/SUB/SLT, write aluout/zero/overflow at the accepting edge, assert done for the following cycle, remain IDLE (latency 1 cycle).
REQ-017 SHALL, for MUL/DIVU/REMU, enter BUSY and load an iteration counter with WIDTH; MUL by shift-add, DIVU/REMU by restoring division, one bit per edge.
REQ-018 SHALL, on the WIDTH-th BUSY edge, write aluout/zero (overflow=0), return to IDLE, and assert done for the following cycle (latency WIDTH cycles, independent of operand values).
REQ-019 SHALL ignore start while BUSY; latched operands and counter unaffected.
REQ-020 SHALL allow a new start in the same cycle done is high (back-to-back issue, one op per cycle for single-cycle ops).
REQ-021 SHALL, for divisor 0, produce DIVU = all ones and REMU = A, still after WIDTH cycles.
REQ-022 SHALL compute ADD/SUB modulo 2^WIDTH; overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from A.
REQ-023 SHALL produce SLT result 1 or 0 zero-extended to WIDTH.
REQ-024 SHALL hold aluout, zero, overflow between completions; done=0 except the single cycle after completion.

Reset
REQ-025 SHALL, at an edge with reset=1, force IDLE, ready=1, done=0, aluout=0, zero=1, overflow=0, counter=0; reset has priority over start.
REQ-026 SHALL, when reset occurs in BUSY, abandon the operation with no done pulse and no aluout update other than clearing.

Verification
REQ-027 Reset for 2 cycles -> ready=1, done=0, aluout=0, zero=1, overflow=0.
REQ-028 WIDTH=32: ADD A=7,B=5 -> aluout=12, zero=0, done high exactly one cycle after accepting edge; SUB 5-5 -> aluout=0, zero=1; ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1; SLT A=0xFFFFFFFF,B=1 -> 1.
REQ-029 MUL A=1234,B=5678 -> aluout=7006652 exactly 32 cycles after accept, ready=0 throughout; start with ADD pulsed mid-op -> ignored, result unchanged.
REQ-030 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each after 32 cycles.
REQ-031 Start MUL, assert reset on 10th BUSY cycle -> next cycle ready=1, aluout=0, no done pulse through following 40 cycles.
REQ-032 WIDTH=8: MUL 16*16 -> aluout=0, zero=1 after 8 cycles; back-to-back ADD 1+1 then ADD 2+2 on consecutive cycles -> 2 then 4, done high both cycles.
